// File: rtl/eif_pkg.sv
// Shared types and helpers for the spike ISI encoder: FSM encoding,
// default widths and a saturating increment.
package eif_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ARMED = 1'b1
   } isi_state_t;

   localparam int ISI_W_DEF = 8;
   localparam int RATE_W    = 8;

   // Increment that sticks at max instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
      return (v >= max) ? max : v + 32'd1;
   endfunction

endpackage

// File: rtl/spike_isi_fifo.sv
// Synchronous first-word-fall-through FIFO; head reads as zero when empty.
// A push into a full FIFO is accepted only when a pop happens the same cycle.
module spike_isi_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             wr_en, rd_en;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign rd_en = pop & ~empty;
   assign wr_en = push & (~full | rd_en);
   assign head  = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // When full, wr_ptr == rd_ptr: the slot being popped is reused as the new tail.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/spike_isi_encoder.sv
// Measures inter-spike intervals into a FIFO and reports a windowed spike rate.
// Optional burst detector enabled by defining SPIKE_ISI_BURST_EN.
module spike_isi_encoder
   import eif_pkg::*;
#(
   parameter int ISI_W      = ISI_W_DEF,
   parameter int FIFO_DEPTH = 4,
   parameter int WIN_LOG2   = 8,
   parameter int BURST_ISI  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              spike_in,
   output logic [ISI_W-1:0]  isi_data,
   output logic              isi_valid,
   input  logic              isi_ready,
   output logic [RATE_W-1:0] rate_out,
   output logic              rate_valid,
   output logic              overflow,
   output logic              burst
);

   localparam logic [31:0] ISI_MAX  = 32'(2**ISI_W - 1);
   localparam logic [31:0] RATE_MAX = 32'(2**RATE_W - 1);

   isi_state_t        state, state_nxt;
   logic [ISI_W-1:0]  isi_cnt, isi_cnt_nxt;
   logic              spike_d, edge_det, edge_en;
   logic              push, pop, fifo_full, fifo_empty;

   logic [WIN_LOG2-1:0] win_cnt;
   logic [RATE_W-1:0]   spk_cnt, spk_cnt_inc;
   logic                win_last;

   assign edge_det = spike_in & ~spike_d;
   assign edge_en  = edge_det & en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         isi_cnt <= '0;
         spike_d <= 1'b0;
      end else begin
         state   <= state_nxt;
         isi_cnt <= isi_cnt_nxt;
         spike_d <= spike_in;
      end
   end

   // Interval counter restarts at 1 on each edge so the pushed value is the
   // number of enabled cycles between consecutive edges.
   always_comb begin
      state_nxt   = state;
      isi_cnt_nxt = isi_cnt;
      push        = 1'b0;
      if (en) begin
         case (state)
            IDLE: begin
               if (edge_det) begin
                  state_nxt   = ARMED;
                  isi_cnt_nxt = ISI_W'(1);
               end
            end
            ARMED: begin
               if (edge_det) begin
                  push        = 1'b1;
                  isi_cnt_nxt = ISI_W'(1);
               end else begin
                  isi_cnt_nxt = ISI_W'(sat_inc(32'(isi_cnt), ISI_MAX));
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign pop       = isi_valid & isi_ready;
   assign isi_valid = ~fifo_empty;

   spike_isi_fifo #(
      .WIDTH (ISI_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (isi_cnt),
      .pop       (pop),
      .head      (isi_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          overflow <= 1'b0;
      else if (push & fifo_full & ~pop) overflow <= 1'b1;
   end

   assign win_last    = &win_cnt;
   assign spk_cnt_inc = edge_en ? RATE_W'(sat_inc(32'(spk_cnt), RATE_MAX)) : spk_cnt;

   // The last window cycle's own edge is folded into the reported count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_cnt    <= '0;
         spk_cnt    <= '0;
         rate_out   <= '0;
         rate_valid <= 1'b0;
      end else begin
         rate_valid <= 1'b0;
         if (en) begin
            win_cnt <= win_cnt + WIN_LOG2'(1);
            if (win_last) begin
               rate_out   <= spk_cnt_inc;
               rate_valid <= 1'b1;
               spk_cnt    <= '0;
            end else begin
               spk_cnt <= spk_cnt_inc;
            end
         end
      end
   end

`ifdef SPIKE_ISI_BURST_EN
   localparam logic [ISI_W-1:0] BURST_LIM = ISI_W'(BURST_ISI);

   logic [1:0] run_cnt;

   // Decision follows the pushed value even when the FIFO drops it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_cnt <= 2'd0;
      end else if (push) begin
         if (isi_cnt < BURST_LIM) run_cnt <= (run_cnt == 2'd3) ? 2'd3 : run_cnt + 2'd1;
         else                     run_cnt <= 2'd0;
      end
   end

   assign burst = (run_cnt == 2'd3);
`else
   assign burst = 1'b0;
`endif

endmodule

// File: tb/tb_spike_isi_encoder.sv
// Directed bench for spike_isi_encoder: ISI timing, saturation, overflow,
// full push/pop, rate window, enable gating, burst flag and async reset.
module tb_spike_isi_encoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       spike_in;
   logic [7:0] isi_data;
   logic       isi_valid;
   logic       isi_ready;
   logic [7:0] rate_out;
   logic       rate_valid;
   logic       overflow;
   logic       burst;

   int n_tests = 0;
   int n_fail  = 0;
   int edge_q[$];

   always #5 clk = ~clk;

   spike_isi_encoder dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .spike_in   (spike_in),
      .isi_data   (isi_data),
      .isi_valid  (isi_valid),
      .isi_ready  (isi_ready),
      .rate_out   (rate_out),
      .rate_valid (rate_valid),
      .overflow   (overflow),
      .burst      (burst)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic bit is_edge(input int c);
      foreach (edge_q[i]) if (edge_q[i] == c) return 1'b1;
      return 1'b0;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Returns 1 time unit after a clock edge; the caller is then in cycle 0.
   task automatic do_reset(input logic rdy);
      rst       = 1'b1;
      en        = 1'b1;
      spike_in  = 1'b0;
      isi_ready = rdy;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      int nw;
      logic [31:0] lastw;

      // Reset values and basic ISI timing: edges 10,15,22 -> 5 then 7.
      rst = 1'b1; en = 1'b1; spike_in = 1'b0; isi_ready = 1'b1;
      cyc();
      check("rst_isi_data",   32'(isi_data),   0);
      check("rst_isi_valid",  32'(isi_valid),  0);
      check("rst_rate_out",   32'(rate_out),   0);
      check("rst_rate_valid", 32'(rate_valid), 0);
      check("rst_overflow",   32'(overflow),   0);
      check("rst_burst",      32'(burst),      0);

      do_reset(1'b1);
      edge_q = '{10, 15, 22};
      for (int c = 0; c <= 30; c++) begin
         spike_in = is_edge(c);
         check("t1_valid", 32'(isi_valid), (c == 16 || c == 23) ? 1 : 0);
         check("t1_data",  32'(isi_data),  (c == 16) ? 5 : ((c == 23) ? 7 : 0));
         cyc();
      end

      // Held-high spike counts once; long gap saturates to 255.
      do_reset(1'b1);
      nw = 0; lastw = 0;
      for (int c = 0; c <= 310; c++) begin
         spike_in = (c < 6) || (c == 305);
         if (isi_valid) begin
            nw++;
            lastw = 32'(isi_data);
         end
         cyc();
      end
      check("t2_words", nw, 1);
      check("t2_sat",   lastw, 255);

      // Overflow: six ISIs (2..7) into a depth-4 FIFO with no consumer.
      do_reset(1'b0);
      edge_q = '{0, 2, 5, 9, 14, 20, 27};
      for (int c = 0; c <= 29; c++) begin
         spike_in = is_edge(c);
         if (c == 20) check("t3_ovf_pre",  32'(overflow), 0);
         if (c == 21) check("t3_ovf_post", 32'(overflow), 1);
         cyc();
      end
      spike_in  = 1'b0;
      isi_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check("t3_drain_valid", 32'(isi_valid), 1);
         check("t3_drain_data",  32'(isi_data),  2 + k);
         cyc();
      end
      check("t3_empty_valid", 32'(isi_valid), 0);
      check("t3_empty_data",  32'(isi_data),  0);
      check("t3_ovf_sticky",  32'(overflow),  1);

      // Full FIFO with simultaneous push and pop.
      do_reset(1'b0);
      edge_q = '{0, 2, 5, 9, 14, 20};
      for (int c = 0; c <= 20; c++) begin
         spike_in  = is_edge(c);
         isi_ready = (c == 20);
         if (c == 20) begin
            check("t4_head_valid", 32'(isi_valid), 1);
            check("t4_head_data",  32'(isi_data),  2);
         end
         cyc();
      end
      spike_in  = 1'b0;
      isi_ready = 1'b0;
      check("t4_no_ovf", 32'(overflow), 0);
      cyc();
      isi_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check("t4_drain_valid", 32'(isi_valid), 1);
         check("t4_drain_data",  32'(isi_data),  3 + k);
         cyc();
      end
      check("t4_empty", 32'(isi_valid), 0);
      check("t4_no_ovf_end", 32'(overflow), 0);

      // Rate window: 3 edges in window 1 (one on its last cycle), none in window 2.
      do_reset(1'b1);
      edge_q = '{50, 100, 255};
      for (int c = 0; c <= 520; c++) begin
         spike_in = is_edge(c);
         check("t5_rate_valid", 32'(rate_valid), (c == 256 || c == 512) ? 1 : 0);
         if (c == 256) check("t5_rate_w1",   32'(rate_out), 3);
         if (c == 300) check("t5_rate_hold", 32'(rate_out), 3);
         if (c == 512) check("t5_rate_w2",   32'(rate_out), 0);
         cyc();
      end

      // en=0 freezes the interval and ignores edges.
      do_reset(1'b1);
      for (int c = 0; c <= 16; c++) begin
         en       = !(c >= 1 && c <= 9);
         spike_in = (c == 0 || c == 5 || c == 14);
         if (c == 6)  check("t6_ignored", 32'(isi_valid), 0);
         if (c == 15) begin
            check("t6_valid", 32'(isi_valid), 1);
            check("t6_data",  32'(isi_data),  5);
         end
         cyc();
      end
      en = 1'b1;

      // Burst: ISIs 3,2,3 then 9.
      do_reset(1'b1);
      edge_q = '{0, 3, 5, 8, 17};
      for (int c = 0; c <= 19; c++) begin
         spike_in = is_edge(c);
         if (c == 8 || c == 9 || c == 17 || c == 18)
`ifdef SPIKE_ISI_BURST_EN
            check("t7_burst", 32'(burst), (c == 9 || c == 17) ? 1 : 0);
`else
            check("t7_burst", 32'(burst), 0);
`endif
         cyc();
      end

      // Asynchronous reset mid-drain with overflow set.
      do_reset(1'b0);
      edge_q = '{0, 2, 5, 9, 14, 20, 27};
      for (int c = 0; c <= 29; c++) begin
         spike_in = is_edge(c);
         cyc();
      end
      spike_in  = 1'b0;
      isi_ready = 1'b1;
      cyc();
      check("t8_mid_data", 32'(isi_data), 3);
      check("t8_mid_ovf",  32'(overflow), 1);
      #2 rst = 1'b1;
      #1;
      check("t8_rst_data",       32'(isi_data),   0);
      check("t8_rst_valid",      32'(isi_valid),  0);
      check("t8_rst_rate",       32'(rate_out),   0);
      check("t8_rst_rate_valid", 32'(rate_valid), 0);
      check("t8_rst_ovf",        32'(overflow),   0);
      check("t8_rst_burst",      32'(burst),      0);
      cyc();
      rst = 1'b0;
      cyc();
      check("t8_after_valid", 32'(isi_valid), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
